keyed_sec_pipe: RTL and testbench

KEYED_SEC_PIPE -- requirements
Module: keyed_sec_pipe

---
 rtl/keyed_sec_pipe_if.sv | 42 ++++
 rtl/keyed_sec_pipe.sv | 184 ++++++++++++++++++
 tb/tb_keyed_sec_pipe.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keyed_sec_pipe_if.sv
// Bus bundle for keyed_sec_pipe: serial key load, input word handshake and
// corrected output handshake. The master side is the environment driving the
// pipe; the slave side is the pipe itself.
interface keyed_sec_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CHK_W  = 6
);
    // Serial key load
    logic              key_load;
    logic              key_bit;
    logic              key_vld;
    logic              key_armed;

    // Input word handshake
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W-1:0]  in_chk;
    logic              in_en;

    // Output word handshake
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_err;

    modport master (
        output key_load, key_bit, key_vld,
        output in_valid, in_data, in_chk, in_en,
        output out_ready,
        input  key_armed, in_ready,
        input  out_valid, out_data, out_err
    );

    modport slave (
        input  key_load, key_bit, key_vld,
        input  in_valid, in_data, in_chk, in_en,
        input  out_ready,
        output key_armed, in_ready,
        output out_valid, out_data, out_err
    );
endinterface

// File: rtl/keyed_sec_pipe.sv
// Keyed single-error-correcting pipeline. A serially loaded key is folded into
// the syndrome (key ^ KEY_SALT), so only the correct key yields clean decoding;
// a wrong or absent key still produces legal handshakes, just corrupted status.
// Two register stages: S1 holds data/en/syndrome, S2 holds corrected output.
module keyed_sec_pipe #(
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      CHK_W    = 6,
    parameter logic [CHK_W-1:0] KEY_SALT = 6'h2A
) (
    input  logic             clk,
    input  logic             rst_n,
    keyed_sec_pipe_if.slave  bus
);

    localparam int unsigned KCW = $clog2(CHK_W);

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_LOADING = 2'd1,
        ST_ARMED   = 2'd2
    } state_t;

    // Syndrome position of data bit idx: the (idx+1)-th integer >= 3 that is
    // not a power of two.
    function automatic int unsigned pos_f(input int unsigned idx);
        int unsigned res;
        int unsigned n;
        res = 0;
        n   = 0;
        for (int unsigned p = 3; p < 256; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx && res == 0) begin
                    res = p;
                end
                n++;
            end
        end
        return res;
    endfunction

    logic [CHK_W-1:0] pos_tbl [DATA_W];

    for (genvar g = 0; g < DATA_W; g++) begin : g_pos
        assign pos_tbl[g] = CHK_W'(pos_f(g));
    end

    // Key FSM state
    state_t           state_q, state_d;
    logic [CHK_W-1:0] key_q, key_d;
    logic [KCW-1:0]   kcnt_q, kcnt_d;

    // Becomes 1 on the first edge after reset release; gates in_ready
    logic             run_q;

    // Pipeline stages
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              s1_en_q;
    logic [CHK_W-1:0]  s1_syn_q, syn_d;

    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [1:0]        s2_err_q, s2_err_d;

    logic              corr_hit;
    logic              advance;
    logic              in_ready;
    logic              in_fire;

    assign advance  = !s2_valid_q || bus.out_ready;
    assign in_ready = run_q && (state_q != ST_LOADING) && advance;
    assign in_fire  = bus.in_valid && in_ready;

    // Key FSM next state: key_load restarts from any state and wins over key_vld
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        kcnt_d  = kcnt_q;
        if (bus.key_load) begin
            state_d = ST_LOADING;
            key_d   = '0;
            kcnt_d  = '0;
        end else begin
            case (state_q)
                ST_LOADING: begin
                    if (bus.key_vld) begin
                        key_d = {bus.key_bit, key_q[CHK_W-1:1]};
                        if (kcnt_q == KCW'(CHK_W - 1)) begin
                            state_d = ST_ARMED;
                            kcnt_d  = '0;
                        end else begin
                            kcnt_d = kcnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Key FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOCKED;
            key_q   <= '0;
            kcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            kcnt_q  <= kcnt_d;
        end
    end

    // Ready enable held low through reset and for the first edge after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Syndrome of the incoming word, folded with the current key state
    always_comb begin
        syn_d = bus.in_chk ^ key_q ^ KEY_SALT;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (bus.in_data[i]) begin
                syn_d = syn_d ^ pos_tbl[i];
            end
        end
    end

    // Correction and status from the syndrome captured in S1
    always_comb begin
        s2_data_d = s1_data_q;
        s2_err_d  = 2'b00;
        corr_hit  = 1'b0;
        if (s1_en_q && (s1_syn_q != '0)) begin
            if ((s1_syn_q & (s1_syn_q - 1'b1)) == '0) begin
                s2_err_d = 2'b10;
            end else begin
                for (int unsigned j = 0; j < DATA_W; j++) begin
                    if (s1_syn_q == pos_tbl[j]) begin
                        s2_data_d[j] = ~s1_data_q[j];
                        corr_hit     = 1'b1;
                    end
                end
                s2_err_d = corr_hit ? 2'b01 : 2'b11;
            end
        end
    end

    // Two-stage pipeline; both stages move together whenever S2 can drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_en_q    <= 1'b0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 2'b00;
        end else if (advance) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_data_q <= bus.in_data;
                s1_en_q   <= bus.in_en;
                s1_syn_q  <= syn_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_err_q  <= s2_err_d;
            end
        end
    end

    assign bus.key_armed = (state_q == ST_ARMED);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_err   = s2_err_q;

endmodule

// File: tb/tb_keyed_sec_pipe.sv
// Directed testbench for keyed_sec_pipe with default parameters.
module tb_keyed_sec_pipe;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    keyed_sec_pipe_if #(.DATA_W(32), .CHK_W(6)) bus ();

    keyed_sec_pipe #(
        .DATA_W  (32),
        .CHK_W   (6),
        .KEY_SALT(6'h2A)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_key(input logic [5:0] k);
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.key_vld = 1'b1;
            bus.key_bit = k[i];
            tick();
        end
        bus.key_vld = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] c, input logic en);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_chk   = c;
        bus.in_en    = en;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.key_armed !== 1'b0) begin bad++; $display("FAIL rst_armed: got %b want 0", bus.key_armed); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        total++; if (bus.out_err !== 2'b00) begin bad++; $display("FAIL rst_out_err: got %b want 00", bus.out_err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_release_ready: got %b want 0", bus.in_ready); end
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_one_cycle_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_key_load();
        logic [5:0] k;
        k = 6'h2A;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL key_loading_ready: got %b want 0", bus.in_ready); end
        for (int i = 0; i < 6; i++) begin
            bus.key_vld = 1'b1;
            bus.key_bit = k[i];
            tick();
            total++; if (bus.key_armed !== (i == 5)) begin bad++; $display("FAIL key_armed_bit%0d: got %b want %b", i, bus.key_armed, (i == 5)); end
        end
        bus.key_vld = 1'b0;
        // restart after 3 bits; the restart cycle carries a valid bit that must be dropped
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        total++; if (bus.key_armed !== 1'b0) begin bad++; $display("FAIL key_restart_armed: got %b want 0", bus.key_armed); end
        for (int i = 0; i < 3; i++) begin
            bus.key_vld = 1'b1;
            bus.key_bit = k[i];
            tick();
        end
        bus.key_load = 1'b1;
        bus.key_vld  = 1'b1;
        bus.key_bit  = 1'b1;
        tick();
        bus.key_load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.key_bit = k[i];
            tick();
            total++; if (bus.key_armed !== (i == 5)) begin bad++; $display("FAIL key_reload_bit%0d: got %b want %b", i, bus.key_armed, (i == 5)); end
        end
        bus.key_vld = 1'b0;
        send(32'h0000_0001, 6'h03, 1'b1);
        tick();
        total++; if (bus.out_err !== 2'b00) begin bad++; $display("FAIL key_reload_clean_err: got %b want 00", bus.out_err); end
        total++; if (bus.out_data !== 32'h1) begin bad++; $display("FAIL key_reload_clean_data: got %h want 00000001", bus.out_data); end
        tick();
    endtask

    task automatic test_armed();
        logic [31:0] vd [9];
        logic [5:0]  vc [9];
        logic        ve [9];
        logic [31:0] xd [9];
        logic [1:0]  xe [9];
        vd = '{32'h1, 32'h11, 32'h1, 32'h31, 32'h8000_0001, 32'h1, 32'h11, 32'h0, 32'h0};
        vc = '{6'h03, 6'h03,  6'h07, 6'h03,  6'h03,        6'h02, 6'h03, 6'h00, 6'h3F};
        ve = '{1'b1,  1'b1,   1'b1,  1'b1,   1'b1,         1'b1,  1'b0,  1'b1,  1'b1};
        xd = '{32'h1, 32'h1,  32'h1, 32'h30, 32'h1,        32'h1, 32'h11, 32'h0, 32'h0};
        xe = '{2'b00, 2'b01,  2'b10, 2'b01,  2'b01,        2'b10, 2'b00, 2'b00, 2'b11};
        for (int v = 0; v < 9; v++) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL armed_ready[%0d]: got %b want 1", v, bus.in_ready); end
            send(vd[v], vc[v], ve[v]);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL armed_early[%0d]: got %b want 0", v, bus.out_valid); end
            tick();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL armed_valid[%0d]: got %b want 1", v, bus.out_valid); end
            total++; if (bus.out_data !== xd[v]) begin bad++; $display("FAIL armed_data[%0d]: got %h want %h", v, bus.out_data, xd[v]); end
            total++; if (bus.out_err !== xe[v]) begin bad++; $display("FAIL armed_err[%0d]: got %b want %b", v, bus.out_err, xe[v]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vd [4];
        logic [5:0]  vc [4];
        logic [1:0]  xe [4];
        vd = '{32'h1, 32'h11, 32'h1, 32'h3};
        vc = '{6'h03, 6'h03, 6'h07, 6'h03};
        xe = '{2'b00, 2'b01, 2'b10, 2'b01};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, bus.in_ready); end
                bus.in_valid = 1'b1;
                bus.in_data  = vd[k];
                bus.in_chk   = vc[k];
                bus.in_en    = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (k >= 2) begin
                total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", k - 2, bus.out_valid); end
                total++; if (bus.out_data !== 32'h1) begin bad++; $display("FAIL b2b_data[%0d]: got %h want 00000001", k - 2, bus.out_data); end
                total++; if (bus.out_err !== xe[k-2]) begin bad++; $display("FAIL b2b_err[%0d]: got %b want %b", k - 2, bus.out_err, xe[k-2]); end
            end
            tick();
        end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        logic [31:0] vd [3];
        logic [5:0]  vc [3];
        int          idx;
        int          acc;
        logic        fire;
        vd = '{32'h11, 32'h1, 32'h3};
        vc = '{6'h03, 6'h07, 6'h03};
        idx = 0;
        acc = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = vd[0];
        bus.in_chk    = vc[0];
        bus.in_en     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            fire = bus.in_valid && bus.in_ready;
            tick();
            if (fire) begin
                acc++;
                idx++;
            end
            if (idx < 3) begin
                bus.in_data = vd[idx];
                bus.in_chk  = vc[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                total++; if (bus.out_data !== 32'h1 || bus.out_err !== 2'b01) begin bad++; $display("FAIL stall_hold[%0d]: got %h/%b want 00000001/01", c, bus.out_data, bus.out_err); end
            end
        end
        total++; if (acc != 2) begin bad++; $display("FAIL stall_accepted: got %0d want 2", acc); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", bus.out_valid); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.out_data !== 32'h1 || bus.out_err !== 2'b01) begin bad++; $display("FAIL stall_out0: got %h/%b want 00000001/01", bus.out_data, bus.out_err); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1 || bus.out_err !== 2'b10) begin bad++; $display("FAIL stall_out1: got %b/%h/%b want 1/00000001/10", bus.out_valid, bus.out_data, bus.out_err); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_locked_wrong();
        do_reset();
        total++; if (bus.key_armed !== 1'b0) begin bad++; $display("FAIL locked_armed: got %b want 0", bus.key_armed); end
        send(32'h1, 6'h03, 1'b1);
        tick();
        total++; if (bus.out_data !== 32'h1 || bus.out_err !== 2'b11) begin bad++; $display("FAIL locked_word: got %h/%b want 00000001/11", bus.out_data, bus.out_err); end
        tick();
        load_key(6'h00);
        total++; if (bus.key_armed !== 1'b1) begin bad++; $display("FAIL wrongkey_armed: got %b want 1", bus.key_armed); end
        send(32'h1, 6'h03, 1'b1);
        tick();
        total++; if (bus.out_data !== 32'h1 || bus.out_err !== 2'b11) begin bad++; $display("FAIL wrongkey_word: got %h/%b want 00000001/11", bus.out_data, bus.out_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        load_key(6'h2A);
        bus.out_ready = 1'b0;
        send(32'h1, 6'h03, 1'b1);
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 32'h0 || bus.out_err !== 2'b00) begin bad++; $display("FAIL midrst_out: got %h/%b want 0/00", bus.out_data, bus.out_err); end
        total++; if (bus.key_armed !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ctrl: got %b/%b want 0/0", bus.key_armed, bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_after: got %b/%b want 1/0", bus.in_ready, bus.out_valid); end
        // reset during a partial key load
        bus.out_ready = 1'b1;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.key_vld = 1'b1;
            bus.key_bit = i[0];
            tick();
        end
        bus.key_vld = 1'b0;
        do_reset();
        total++; if (bus.key_armed !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL loadrst_state: got %b/%b want 0/1", bus.key_armed, bus.in_ready); end
        send(32'h1, 6'h03, 1'b1);
        tick();
        total++; if (bus.out_data !== 32'h1 || bus.out_err !== 2'b11) begin bad++; $display("FAIL loadrst_word: got %h/%b want 00000001/11", bus.out_data, bus.out_err); end
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.key_load  = 1'b0;
        bus.key_bit   = 1'b0;
        bus.key_vld   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_chk    = '0;
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b1;

        test_reset();
        test_key_load();
        test_armed();
        test_back_to_back();
        test_stall();
        test_locked_wrong();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
